// File: rtl/s27_out_monitor_if.sv
// s27_out_monitor_if: bundle between s27 checker and its monitor; inputs EN/VLD/G17/GOLD/CLR, results BUSY/MISMATCH/ALARM/SCNT/MCNT/FIRST_IDX
interface s27_out_monitor_if #(parameter int CNT_W = 16);
  logic EN, VLD, G17, GOLD, CLR;
  logic BUSY, MISMATCH, ALARM;
  logic [CNT_W-1:0] SCNT, MCNT, FIRST_IDX;
  modport master (output EN, VLD, G17, GOLD, CLR, input BUSY, MISMATCH, ALARM, SCNT, MCNT, FIRST_IDX);
  modport slave (input EN, VLD, G17, GOLD, CLR, output BUSY, MISMATCH, ALARM, SCNT, MCNT, FIRST_IDX);
endinterface

// File: rtl/s27_out_monitor.sv
// s27_out_monitor: flags runs of G17/GOLD mismatches as trojan activity; ports CK, RSTN (async low), bus (slave: EN/VLD/G17/GOLD/CLR in, BUSY/MISMATCH/ALARM/SCNT/MCNT/FIRST_IDX out)
module s27_out_monitor #(
  parameter int CNT_W = 16,
  parameter int THRESH = 4
) (
  input logic CK,
  input logic RSTN,
  s27_out_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MON, ALERT} state_t;
  state_t state_q;
  logic mism_q, alarm_q, acc, mm, hit;
  logic [CNT_W-1:0] scnt_q, mcnt_q, first_q, scnt_d, mcnt_d;
  logic [7:0] run_q, run_d;
  always_comb begin
    acc = bus.VLD && bus.EN;
    mm = bus.G17 ^ bus.GOLD;
    scnt_d = &scnt_q ? scnt_q : scnt_q + CNT_W'(1);
    mcnt_d = &mcnt_q ? mcnt_q : mcnt_q + CNT_W'(1);
    run_d = mm ? (&run_q ? run_q : run_q + 8'd1) : 8'd0;
    hit = acc && mm && run_d == 8'(THRESH);
  end
  always_ff @(posedge CK or negedge RSTN)
    if (!RSTN) begin
      state_q <= IDLE;
      mism_q <= 1'b0;
      alarm_q <= 1'b0;
      scnt_q <= '0;
      mcnt_q <= '0;
      first_q <= '0;
      run_q <= '0;
    end else begin
      mism_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.EN) begin
          state_q <= MON;
          scnt_q <= '0;
          mcnt_q <= '0;
          first_q <= '0;
          run_q <= '0;
        end
        MON, ALERT: begin
          if (state_q == ALERT && bus.CLR) begin
            state_q <= IDLE;
            alarm_q <= 1'b0;
            run_q <= '0;
          end else if (state_q == MON && !bus.EN) begin
            state_q <= IDLE;
          end else if (acc) begin
            scnt_q <= scnt_d;
            run_q <= run_d;
            mism_q <= mm;
            if (mm) mcnt_q <= mcnt_d;
            // capture uses the pre-increment count, already clamped at all-ones
            if (mm && mcnt_q == '0) first_q <= scnt_q;
            if (state_q == MON && hit) begin
              state_q <= ALERT;
              alarm_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.BUSY = state_q != IDLE;
  assign bus.MISMATCH = mism_q;
  assign bus.ALARM = alarm_q;
  assign bus.SCNT = scnt_q;
  assign bus.MCNT = mcnt_q;
  assign bus.FIRST_IDX = first_q;
endmodule

// File: tb/tb_s27_out_monitor.sv
// tb_s27_out_monitor: scoreboard bench driving two monitors (THRESH 4 and 255, 4-bit counters) against a behavioural model
module tb_s27_out_monitor;
  localparam int MX = 15;
  typedef struct {
    int k;
    int busy, mism, alarm, scnt, mcnt, first;
    string tag;
  } exp_t;
  logic CK = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b0, vld = 1'b0, g = 1'b0, gold = 1'b0, clr = 1'b0;
  int tests = 0, fails = 0;
  int th[2] = '{4, 255};
  int busy[2], alarm[2], scnt[2], mcnt[2], first[2], run[2], mism[2];
  exp_t q[$];
  exp_t e;
  event chk;
  always #5 CK = ~CK;
  s27_out_monitor_if #(.CNT_W(4)) ifa();
  s27_out_monitor_if #(.CNT_W(4)) ifb();
  assign ifa.EN = en;
  assign ifa.VLD = vld;
  assign ifa.G17 = g;
  assign ifa.GOLD = gold;
  assign ifa.CLR = clr;
  assign ifb.EN = en;
  assign ifb.VLD = vld;
  assign ifb.G17 = g;
  assign ifb.GOLD = gold;
  assign ifb.CLR = clr;
  s27_out_monitor #(.CNT_W(4), .THRESH(4)) dut_a (.CK(CK), .RSTN(rstn), .bus(ifa));
  s27_out_monitor #(.CNT_W(4), .THRESH(255)) dut_b (.CK(CK), .RSTN(rstn), .bus(ifb));

  function automatic int sat(int v, int m);
    return v > m ? m : v;
  endfunction

  task automatic model_edge(int k);
    bit bad;
    bad = g ^ gold;
    if (!rstn) begin
      busy[k] = 0; alarm[k] = 0; scnt[k] = 0; mcnt[k] = 0; first[k] = 0; run[k] = 0; mism[k] = 0;
      return;
    end
    mism[k] = 0;
    if (busy[k] == 0) begin
      if (en) begin
        busy[k] = 1; scnt[k] = 0; mcnt[k] = 0; first[k] = 0; run[k] = 0;
      end
    end else if (alarm[k] == 1 && clr) begin
      busy[k] = 0; alarm[k] = 0; run[k] = 0;
    end else if (alarm[k] == 0 && !en) begin
      busy[k] = 0;
    end else if (vld && en) begin
      if (bad && mcnt[k] == 0) first[k] = scnt[k];
      scnt[k] = sat(scnt[k] + 1, MX);
      if (bad) begin
        mcnt[k] = sat(mcnt[k] + 1, MX);
        run[k] = sat(run[k] + 1, 255);
        if (run[k] == th[k]) alarm[k] = 1;
      end else run[k] = 0;
      mism[k] = int'(bad);
    end
  endtask

  task automatic push_all(string tag);
    for (int k = 0; k < 2; k++) begin
      model_edge(k);
      q.push_back('{k, busy[k], mism[k], alarm[k], scnt[k], mcnt[k], first[k], tag});
    end
  endtask

  task automatic step(input bit e_i, v_i, g_i, o_i, c_i, input string tag);
    en = e_i; vld = v_i; g = g_i; gold = o_i; clr = c_i;
    @(posedge CK);
    #1;
    push_all(tag);
  endtask

  task automatic async_rst(string tag);
    @(negedge CK);
    #1 rstn = 1'b0;
    #1 push_all(tag);
    ->chk;
  endtask

  function automatic logic [14:0] dut_out(int k);
    return k == 0 ? {ifa.BUSY, ifa.MISMATCH, ifa.ALARM, ifa.SCNT, ifa.MCNT, ifa.FIRST_IDX}
                  : {ifb.BUSY, ifb.MISMATCH, ifb.ALARM, ifb.SCNT, ifb.MCNT, ifb.FIRST_IDX};
  endfunction

  initial forever begin
    logic [14:0] got, want;
    @(negedge CK or chk);
    while (q.size() != 0) begin
      e = q.pop_front();
      got = dut_out(e.k);
      want = {1'(e.busy), 1'(e.mism), 1'(e.alarm), 4'(e.scnt), 4'(e.mcnt), 4'(e.first)};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL %s dut%0d busy/mism/alarm/scnt/mcnt/first got=%b/%b/%b/%0d/%0d/%0d want=%b/%b/%b/%0d/%0d/%0d",
                 e.tag, e.k, got[14], got[13], got[12], got[11:8], got[7:4], got[3:0],
                 want[14], want[13], want[12], want[11:8], want[7:4], want[3:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit b;
    bit [7:0] pat;
    for (int k = 0; k < 2; k++) begin
      busy[k] = 0; alarm[k] = 0; scnt[k] = 0; mcnt[k] = 0; first[k] = 0; run[k] = 0; mism[k] = 0;
    end
    step(1, 1, 1, 0, 0, "reset");
    step(1, 1, 0, 1, 1, "reset");
    rstn = 1'b1;
    step(1, 0, 0, 0, 0, "enter");
    for (int i = 0; i < 10; i++) begin
      b = 1'($urandom);
      step(1, 1, b, b, 0, "match10");
    end
    tests++;
    if (ifa.SCNT !== 4'd10 || ifa.MCNT !== 4'd0 || ifa.ALARM !== 1'b0 || ifb.SCNT !== 4'd10) begin
      fails++;
      $display("FAIL match10_direct scnt=%0d mcnt=%0d alarm=%b", ifa.SCNT, ifa.MCNT, ifa.ALARM);
    end
    step(0, 1, 1, 0, 0, "idle_ignores_vld");
    step(0, 1, 1, 0, 1, "idle_ignores_clr");
    step(1, 0, 0, 0, 0, "enter");
    pat = 8'b11110110;
    for (int i = 0; i < 8; i++) step(1, 1, pat[i], 1'b0, 0, "thresh_pattern");
    tests++;
    if (ifa.FIRST_IDX !== 4'd1 || ifa.MCNT !== 4'd6 || ifa.ALARM !== 1'b1) begin
      fails++;
      $display("FAIL thresh_direct first=%0d mcnt=%0d alarm=%b", ifa.FIRST_IDX, ifa.MCNT, ifa.ALARM);
    end
    step(1, 1, 1, 1, 0, "alert_holds");
    step(1, 1, 1, 0, 1, "clr_drops_sample");
    step(0, 0, 0, 0, 1, "to_idle");
    step(1, 0, 0, 0, 0, "enter");
    for (int i = 0; i < 20; i++) step(1, 1, 0, 1, 0, "saturate");
    tests++;
    if (ifb.SCNT !== 4'd15 || ifb.MCNT !== 4'd15 || ifb.ALARM !== 1'b0) begin
      fails++;
      $display("FAIL saturate_direct scnt=%0d mcnt=%0d alarm=%b", ifb.SCNT, ifb.MCNT, ifb.ALARM);
    end
    step(0, 0, 0, 0, 1, "to_idle");
    step(1, 0, 0, 0, 0, "enter");
    for (int i = 0; i < 7; i++) step(1, 1, i >= 3, 1'b0, 0, "reach_alert7");
    async_rst("async_reset");
    step(1, 1, 1, 0, 0, "held_reset");
    rstn = 1'b1;
    step(1, 1, 1, 0, 0, "restart");
    step(1, 1, 0, 0, 0, "restart");
    step(1, 1, 1, 1, 0, "restart");
    step(0, 0, 0, 0, 0, "to_idle");
    step(1, 0, 0, 0, 0, "enter");
    for (int i = 0; i < 3; i++) step(1, 1, 1'(i), 1'b0, 0, "three_samples");
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, "en_dropped");
    step(1, 1, 1, 0, 0, "reenter_zero");
    step(1, 1, 1, 0, 0, "reenter_count");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_rst("rand_async");
        step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, "rand_held");
        rstn = 1'b1;
      end
      b = 1'($urandom);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, b,
           ($urandom_range(0, 9) < 4) ? ~b : b, $urandom_range(0, 11) == 0, "random");
    end
    @(negedge CK);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
